fir_serial_mac_ctrl: RTL and testbench

//  Time-multiplexed FIR controller: sequences one shared multiplier/accumulator over TAPS coefficients per input sample.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 40 ++++
 rtl/fir_serial_mac_ctrl.sv | 105 ++++++++++
 tb/tb_fir_serial_mac_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, default coefficients, FSM states and output saturation for the serial FIR.
package fir_pkg;
    localparam int DEF_TAPS  = 5;
    localparam int DEF_DW    = 10;
    localparam int DEF_CW    = 10;
    localparam int DEF_OUT_W = 20;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_OUT} fir_state_e;

    // Symmetric low-pass default (sfix En8); taps past the table read as zero.
    function automatic int default_coeff(input int idx);
        case (idx)
            0:       return 'h066;
            1:       return 'h0CD;
            2:       return 'h100;
            3:       return 'h0CD;
            4:       return 'h066;
            default: return 0;
        endcase
    endfunction

    // Clamp a sign-extended value into a w-bit signed range.
    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply followed by accumulate; saturated view of the accumulator.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int ACC_W = DEF_DW + DEF_CW + 3,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_x,
    input  logic                    acc_clr,
    input  logic                    mul_en,
    input  logic signed [CW-1:0]    coeff,
    input  logic signed [DW-1:0]    sample,
    output logic signed [OUT_W-1:0] sat_acc
);
    localparam int PW = DW + CW;

    logic signed [PW-1:0]    prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      acc_wide;

    // Product lands one cycle after its tap is presented, and is summed the cycle after that.
    always_ff @(posedge clk) begin
        if (!rst_x || acc_clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= mul_en;
            if (mul_en)   prod <= PW'(coeff) * PW'(sample);
            if (prod_vld) acc  <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
        end
    end

    assign acc_wide = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign sat_acc  = OUT_W'(sat_to_out(acc_wide, OUT_W));
endmodule

// File: rtl/fir_serial_mac_ctrl.sv
// Serial FIR controller: one shared MAC stepped over TAPS coefficients per accepted sample.
module fir_serial_mac_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS  = DEF_TAPS,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ACC_W = DW + CW + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_x,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DW-1:0]      filter_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   filter_out,
    input  logic                      cfg_we,
    input  logic [$clog2(TAPS)-1:0]   cfg_addr,
    input  logic signed [CW-1:0]      cfg_data,
    output logic                      cfg_ready,
    output logic                      busy
);
    localparam int AW = $clog2(TAPS);

    fir_state_e           state, state_nx;
    logic [AW-1:0]        wr_ptr, rd_ptr, tap;
    logic signed [DW-1:0] dline [TAPS];
    logic signed [CW-1:0] coeff [TAPS];
    logic                 accept, last_tap, drain_done;
    logic signed [OUT_W-1:0] sat_acc;

    assign in_ready   = (state == ST_IDLE) && !clear;
    assign accept     = in_valid && in_ready;
    assign cfg_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_OUT);
    assign last_tap   = (tap == AW'(TAPS - 1));
    // DRAIN spans two cycles: fold in the last product, then latch the saturated sum.
    assign drain_done = (state == ST_DRAIN) && (tap != '0);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept)     state_nx = ST_MAC;
            ST_MAC:   if (last_tap)   state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nx = ST_OUT;
            ST_OUT:   if (out_ready)  state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
        if (clear) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_x) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_x || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tap    <= '0;
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
        end else if (accept) begin
            dline[wr_ptr] <= filter_in;
            wr_ptr        <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
            rd_ptr        <= wr_ptr;
            tap           <= '0;
        end else if (state == ST_MAC) begin
            // Walk backwards from the newest sample so tap k sees the sample k accepts old.
            rd_ptr <= (rd_ptr == '0) ? AW'(TAPS - 1) : rd_ptr - 1'b1;
            tap    <= last_tap ? '0 : tap + 1'b1;
        end else if (state == ST_DRAIN) begin
            tap <= tap + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= CW'(default_coeff(i));
        end else if (cfg_we && cfg_ready && (int'(cfg_addr) < TAPS)) begin
            coeff[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_x)                   filter_out <= '0;
        else if (drain_done && !clear) filter_out <= sat_acc;
    end

    fir_mac_unit #(
        .DW(DW), .CW(CW), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) u_mac (
        .clk     (clk),
        .rst_x   (rst_x),
        .acc_clr (accept || clear),
        .mul_en  ((state == ST_MAC) && !clear),
        .coeff   (coeff[tap]),
        .sample  (dline[rd_ptr]),
        .sat_acc (sat_acc)
    );
endmodule

// File: tb/tb_fir_serial_mac_ctrl.sv
// Directed bench for fir_serial_mac_ctrl: vector table plus hand-written corner sequences.
module tb_fir_serial_mac_ctrl;
    logic clk = 1'b0;
    logic rst_x, clear, in_valid, in_ready, out_valid, out_ready;
    logic cfg_we, cfg_ready, busy;
    logic signed [9:0]  filter_in, cfg_data;
    logic signed [19:0] filter_out;
    logic [2:0] cfg_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] s;
        int         exp;
    } vec_t;
    vec_t tbl [16];

    fir_serial_mac_ctrl dut (
        .clk(clk), .rst_x(rst_x), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .filter_in(filter_in),
        .out_valid(out_valid), .out_ready(out_ready), .filter_out(filter_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_x = 1'b0;
        @(posedge clk); #1 rst_x = 1'b1;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [9:0] d);
        int n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    // Returns #1 after the accepting edge.
    task automatic push_start(input logic [9:0] s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin errors++; $display("FAIL in_ready_timeout: got 0 expected 1"); end
        in_valid = 1'b1; filter_in = s;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    // Counts edges until out_valid; returns #1 after the edge that raised it.
    task automatic wait_out(output int y, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) begin errors++; $display("FAIL out_valid_timeout: got 0 expected 1"); end
        y = int'(filter_out);
    endtask

    task automatic run_table(input int lo, input int hi);
        int y, lat;
        for (int i = lo; i <= hi; i++) begin
            push_start(tbl[i].s);
            wait_out(y, lat);
            chk($sformatf("vec%0d_out", i), y, tbl[i].exp);
            chk($sformatf("vec%0d_lat", i), lat, 7);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse", i), int'(out_valid), 0);
            chk($sformatf("vec%0d_ready", i), int'(in_ready), 1);
        end
    endtask

    initial begin
        int y, lat, seen, stable_bad;

        tbl[0]  = '{10'h100, 26112};  tbl[1]  = '{10'h000, 52480};
        tbl[2]  = '{10'h000, 65536};  tbl[3]  = '{10'h000, 52480};
        tbl[4]  = '{10'h000, 26112};  tbl[5]  = '{10'h000, 0};
        tbl[6]  = '{10'h1FF, 261121}; tbl[7]  = '{10'h1FF, 522242};
        tbl[8]  = '{10'h1FF, 524287}; tbl[9]  = '{10'h1FF, 524287};
        tbl[10] = '{10'h1FF, 524287};
        tbl[11] = '{10'h200, 524287}; tbl[12] = '{10'h200, 260099};
        tbl[13] = '{10'h200, -262654}; tbl[14] = '{10'h200, -524288};
        tbl[15] = '{10'h200, -524288};

        rst_x = 1'b0; clear = 1'b0; in_valid = 1'b0; filter_in = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_filter_out", int'(filter_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        rst_x = 1'b1;

        // Impulse response with default coefficients
        run_table(0, 5);

        // Saturation, positive then negative
        for (int k = 0; k < 5; k++) cfg_write(3'(k), 10'h1FF);
        run_table(6, 15);

        // Backpressure: result held while downstream stalls, upstream held off
        do_reset();
        out_ready = 1'b0;
        push_start(10'h100);
        wait_out(y, lat);
        chk("bp_first", y, 26112);
        @(negedge clk); in_valid = 1'b1; filter_in = 10'h000;
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || filter_out != 26112 || in_ready || !busy) stable_bad++;
        end
        chk("bp_stable", stable_bad, 0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("bp_held_accepted", int'(busy), 1);
        wait_out(y, lat);
        chk("bp_second", y, 52480);

        // Config write during MAC is dropped
        do_reset();
        push_start(10'h100);
        @(negedge clk);
        chk("cfg_ready_mac", int'(cfg_ready), 0);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 10'h100;
        @(posedge clk); #1 cfg_we = 1'b0;
        wait_out(y, lat);
        chk("cfg_dropped", y, 26112);
        cfg_write(3'd0, 10'h100);
        do_clear();
        push_start(10'h100);
        wait_out(y, lat);
        chk("cfg_applied", y, 65536);

        // Write in the accepting cycle applies to that sample
        do_clear();
        @(negedge clk);
        in_valid = 1'b1; filter_in = 10'h100;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 10'h033;
        @(posedge clk); #1 in_valid = 1'b0; cfg_we = 1'b0;
        wait_out(y, lat);
        chk("cfg_same_cycle", y, 13056);

        // Clear mid-MAC: no output, delay line flushed
        do_reset();
        push_start(10'h100);
        repeat (2) @(posedge clk);
        do_clear();
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("clr_no_out", seen, 0);
        chk("clr_busy", int'(busy), 0);
        run_table(0, 5);

        // Clear wins over a simultaneous in_valid
        @(negedge clk); clear = 1'b1; in_valid = 1'b1; filter_in = 10'h100;
        #1 chk("clr_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
        chk("clr_not_accepted", int'(busy), 0);

        // Reset mid-MAC: same as clear
        push_start(10'h100);
        repeat (2) @(posedge clk);
        do_reset();
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_no_out", seen, 0);
        run_table(0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
